// File: rtl/mux_sel_ctrl.sv
// mux_sel_ctrl: round-robin select controller for a 2:1 data mux.
// Ports: clk, rst_n (async low); req_a/req_b in; sel/gnt_a/gnt_b/busy/switch_cnt out.
module mux_sel_ctrl #(
  parameter int unsigned BURST_LEN = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_a,
  input  logic       req_b,
  output logic       sel,
  output logic       gnt_a,
  output logic       gnt_b,
  output logic       busy,
  output logic [7:0] switch_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    GRANT_A,
    GRANT_B,
    TURN
  } state_e;

  localparam logic [7:0] LOAD = 8'(BURST_LEN - 1);

  state_e     state_q, state_d;
  logic       sel_q, sel_d;
  logic       last_q, last_d;
  logic       pend_q, pend_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] sw_q, sw_d;

  logic       any_req;
  logic       win_a;
  logic [7:0] sw_inc;

  // last_q/pend_q: 1 = A, 0 = B (same sense as sel)
  assign any_req = req_a | req_b;
  assign win_a   = (req_a & ~req_b) | (req_a & req_b & ~last_q);
  assign sw_inc  = (sw_q == 8'hFF) ? sw_q : sw_q + 8'd1;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    pend_d  = pend_q;
    cnt_d   = cnt_q;
    sw_d    = sw_q;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          if (win_a == sel_q) begin
            state_d = win_a ? GRANT_A : GRANT_B;
            cnt_d   = LOAD;
          end else begin
            state_d = TURN;
            pend_d  = win_a;
            sel_d   = win_a;
            sw_d    = sw_inc;
          end
        end
      end
      TURN: begin
        // grant the captured winner even if it dropped its request
        state_d = pend_q ? GRANT_A : GRANT_B;
        cnt_d   = LOAD;
      end
      GRANT_A: begin
        if ((cnt_q == 8'd0) || !req_a) begin
          last_d = 1'b1;
          if (req_b) begin
            state_d = TURN;
            pend_d  = 1'b0;
            sel_d   = 1'b0;
            sw_d    = sw_inc;
          end else if (req_a) begin
            cnt_d = LOAD;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      GRANT_B: begin
        if ((cnt_q == 8'd0) || !req_b) begin
          last_d = 1'b0;
          if (req_a) begin
            state_d = TURN;
            pend_d  = 1'b1;
            sel_d   = 1'b1;
            sw_d    = sw_inc;
          end else if (req_b) begin
            cnt_d = LOAD;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= 1'b0;
      last_q  <= 1'b0;
      pend_q  <= 1'b0;
      cnt_q   <= 8'd0;
      sw_q    <= 8'd0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      sw_q    <= sw_d;
    end
  end

  assign sel        = sel_q;
  assign gnt_a      = (state_q == GRANT_A);
  assign gnt_b      = (state_q == GRANT_B);
  assign busy       = (state_q != IDLE);
  assign switch_cnt = sw_q;

endmodule

// File: tb/tb_mux_sel_ctrl.sv
// tb_mux_sel_ctrl: directed bench for mux_sel_ctrl.
// Drives BURST_LEN=4 and BURST_LEN=1 instances.
module tb_mux_sel_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, ra, rb;
  logic       sel, ga, gb, busy;
  logic [7:0] sw;
  logic       r1_n, ra1, rb1;
  logic       sel1, ga1, gb1, busy1;
  logic [7:0] sw1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mux_sel_ctrl #(.BURST_LEN(4)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_a(ra), .req_b(rb),
    .sel(sel), .gnt_a(ga), .gnt_b(gb),
    .busy(busy), .switch_cnt(sw)
  );

  mux_sel_ctrl #(.BURST_LEN(1)) u_dut1 (
    .clk(clk), .rst_n(r1_n),
    .req_a(ra1), .req_b(rb1),
    .sel(sel1), .gnt_a(ga1), .gnt_b(gb1),
    .busy(busy1), .switch_cnt(sw1)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic a, input logic b);
    rst_n = 1'b0;
    ra    = a;
    rb    = b;
    #3;
    rst_n = 1'b1;
  endtask

  logic sel_prev  = 1'b0;
  logic sel1_prev = 1'b0;

  always @(negedge clk) begin
    chk("excl", {31'd0, ga & gb}, 0);
    if (sel !== sel_prev) chk("gnt_at_sel_chg", {31'd0, ga | gb}, 0);
    if (ga) chk("sel_when_a", {31'd0, sel}, 1);
    if (gb) chk("sel_when_b", {31'd0, sel}, 0);
    sel_prev = sel;
    chk("excl1", {31'd0, ga1 & gb1}, 0);
    if (sel1 !== sel1_prev) chk("gnt_at_sel_chg1", {31'd0, ga1 | gb1}, 0);
    if (ga1) chk("sel_when_a1", {31'd0, sel1}, 1);
    if (gb1) chk("sel_when_b1", {31'd0, sel1}, 0);
    sel1_prev = sel1;
  end

  initial begin
    string pat;
    string spat;
    int    swe;
    int    exp_sw;
    rst_n = 1'b0; ra = 1'b0; rb = 1'b0;
    r1_n  = 1'b0; ra1 = 1'b0; rb1 = 1'b0;
    #12;
    chk("rst_gnt_a", {31'd0, ga}, 0);
    chk("rst_gnt_b", {31'd0, gb}, 0);
    chk("rst_sel", {31'd0, sel}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_sw", {24'd0, sw}, 0);

    // B alone: sel already 0, grant next cycle, no gaps
    rst_n = 1'b1;
    rb    = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      chk("bonly_gnt_b", {31'd0, gb}, 1);
      chk("bonly_gnt_a", {31'd0, ga}, 0);
      chk("bonly_sel", {31'd0, sel}, 0);
      chk("bonly_busy", {31'd0, busy}, 1);
    end
    chk("bonly_sw", {24'd0, sw}, 0);
    rb = 1'b0;
    step();
    chk("bdrop_gnt_b", {31'd0, gb}, 0);
    chk("bdrop_busy", {31'd0, busy}, 0);

    // both requesting: T A A A A T B B B B T A
    do_reset(1'b1, 1'b1);
    pat  = "TAAAATBBBBTA";
    spat = "111110000011";
    swe  = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (pat[i] == "T") swe++;
      chk("both_gnt_a", {31'd0, ga}, {31'd0, pat[i] == "A"});
      chk("both_gnt_b", {31'd0, gb}, {31'd0, pat[i] == "B"});
      chk("both_sel", {31'd0, sel}, {31'd0, spat[i] == "1"});
      chk("both_sw", {24'd0, sw}, swe);
    end

    // early release of A after 2 grant cycles
    do_reset(1'b1, 1'b1);
    step();
    chk("er_turn_sel", {31'd0, sel}, 1);
    chk("er_turn_gnt", {30'd0, ga, gb}, 0);
    step();
    chk("er_a1", {31'd0, ga}, 1);
    step();
    chk("er_a2", {31'd0, ga}, 1);
    ra = 1'b0;
    step();
    chk("er_a_drop", {31'd0, ga}, 0);
    chk("er_turn2_gb", {31'd0, gb}, 0);
    chk("er_turn2_sel", {31'd0, sel}, 0);
    chk("er_turn2_sw", {24'd0, sw}, 2);
    step();
    chk("er_gnt_b", {31'd0, gb}, 1);
    chk("er_gnt_b_sel", {31'd0, sel}, 0);

    // async reset mid-burst
    do_reset(1'b1, 1'b1);
    step();
    step();
    step();
    chk("ar_pre_gnt_a", {31'd0, ga}, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_gnt_a", {31'd0, ga}, 0);
    chk("ar_busy", {31'd0, busy}, 0);
    chk("ar_sw", {24'd0, sw}, 0);
    chk("ar_sel", {31'd0, sel}, 0);
    #2;
    rst_n = 1'b1;
    step();
    chk("ar_replay_sel", {31'd0, sel}, 1);
    chk("ar_replay_gnt", {30'd0, ga, gb}, 0);
    chk("ar_replay_busy", {31'd0, busy}, 1);
    chk("ar_replay_sw", {24'd0, sw}, 1);
    step();
    chk("ar_replay_a", {31'd0, ga}, 1);
    ra = 1'b0;
    rb = 1'b0;

    // BURST_LEN=1, both requesting for 600 cycles
    r1_n = 1'b1;
    ra1  = 1'b1;
    rb1  = 1'b1;
    for (int n = 1; n <= 600; n++) begin
      step();
      exp_sw = (n + 1) / 2;
      if (exp_sw > 255) exp_sw = 255;
      chk("b1_gnt_a", {31'd0, ga1}, {31'd0, (n % 4) == 2});
      chk("b1_gnt_b", {31'd0, gb1}, {31'd0, (n % 4) == 0});
      chk("b1_sel", {31'd0, sel1}, {31'd0, ((n % 4) == 1) || ((n % 4) == 2)});
      chk("b1_sw", {24'd0, sw1}, exp_sw);
    end
    chk("b1_sw_sat", {24'd0, sw1}, 255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
